// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 size codes, FSM encoding and access helpers
//            for the data-memory load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Only B/H/W carry a store size; the unsigned codes write nothing.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << lo;
            F3_H:    be = 4'b0011 << lo;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Brief    : Selects the addressed byte/halfword lane of a loaded word and
//            sign- or zero-extends it according to funct3.
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_word >> {i_addr_lo, 3'b000};
        case (i_funct3)
            F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_data = i_word;
            F3_BU:   o_data = {24'd0, w_shifted[7:0]};
            F3_HU:   o_data = {16'd0, w_shifted[15:0]};
            default: o_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : MEM-stage data memory with sub-word access, registered-read
//            valid/ready handshake, fault detection and a sticky done flag.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int            DEPTH     = 1024,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] DONE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [2:0]    req_funct3,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_fault,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_rdata,
    output logic          done_flag
);

    localparam int c_IW = $clog2(DEPTH);

    lsu_state_t r_state;
    lsu_state_t w_state_next;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_fault;
    logic          r_done;

    logic [c_IW-1:0] w_idx;
    logic [1:0]      w_lo;
    logic            w_req_ready;
    logic            w_accept;
    logic            w_oob;
    logic            w_misalign;
    logic            w_fault;
    logic            w_store_en;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_load_data;
    logic            w_unused;

    assign w_idx = req_addr[c_IW+1:2];
    assign w_lo  = req_addr[1:0];

    // Any set bit above the array's byte span means out of range.
    generate
        if (AW > c_IW + 2) begin : g_range_check
            assign w_oob = |req_addr[AW-1:c_IW+2];
        end else begin : g_range_full
            assign w_oob = 1'b0;
        end
    endgenerate

    assign w_misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && w_lo[0]) ||
                        ((req_funct3 == F3_W) && (w_lo != 2'b00));
    assign w_fault    = !f3_legal(req_funct3) || w_misalign || w_oob;

    assign w_req_ready = (r_state == ST_IDLE) || rsp_ready;
    assign w_accept    = req_valid && w_req_ready;
    assign w_store_en  = w_accept && req_we && !w_fault && !rst;
    assign w_be        = byte_enable(req_funct3, w_lo);

    always_comb begin
        case (req_funct3)
            F3_B:    w_wdata = {4{req_wdata[7:0]}};
            F3_H:    w_wdata = {2{req_wdata[15:0]}};
            default: w_wdata = req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .i_word    (r_mem[w_idx]),
        .i_addr_lo (w_lo),
        .i_funct3  (req_funct3),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready && !w_accept) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Response registers only load on acceptance, so they hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_fault <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rsp_fault <= w_fault;
                r_rsp_rdata <= (!req_we && !w_fault) ? w_load_data : 32'd0;
            end
            if (w_store_en && (req_addr == DONE_ADDR)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;
    assign done_flag = r_done;
    assign dbg_rdata = r_mem[dbg_addr[c_IW-1:0]];

    assign w_unused = ^dbg_addr[AW-1:c_IW];

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Directed self-checking bench for dmem_lsu (64-word array).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

    localparam int          DEPTH = 64;
    localparam int          AW    = 32;
    localparam logic [2:0]  c_B   = 3'b000;
    localparam logic [2:0]  c_H   = 3'b001;
    localparam logic [2:0]  c_W   = 3'b010;
    localparam logic [2:0]  c_BU  = 3'b100;
    localparam logic [2:0]  c_HU  = 3'b101;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_funct3;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_fault;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_rdata;
    logic          done_flag;

    int checks   = 0;
    int failures = 0;

    dmem_lsu #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .DONE_ADDR ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata),
        .done_flag  (done_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request with rsp_ready high and returns 1 ns after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        rsp_ready  = 1'b1;
        n = 0;
        while (!req_ready && n < 8) begin
            step();
            n++;
        end
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = c_W;
        rsp_ready  = 1'b1;
        dbg_addr   = '0;
        step();
        step();

        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst_done", {31'd0, done_flag}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        step();

        // Word round trip
        issue(1'b1, 32'h40, 32'hDEADBEEF, c_W);
        chk("sw_latency", {31'd0, rsp_valid}, 32'd1);
        chk("sw_rdata", rsp_rdata, 32'd0);
        chk("sw_fault", {31'd0, rsp_fault}, 32'd0);
        chk("sw_done_clear", {31'd0, done_flag}, 32'd0);
        issue(1'b0, 32'h40, 32'd0, c_W);
        chk("lw_latency", {31'd0, rsp_valid}, 32'd1);
        chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("lw_fault", {31'd0, rsp_fault}, 32'd0);

        // Sub-word stores and extended loads
        issue(1'b1, 32'h80, 32'h0, c_W);
        issue(1'b1, 32'h82, 32'h80, c_B);
        dbg_addr = 32'h20;
        #1;
        chk("sb_dbg", dbg_rdata, 32'h00800000);
        issue(1'b0, 32'h82, 32'd0, c_B);
        chk("lb_sign", rsp_rdata, 32'hFFFFFF80);
        issue(1'b0, 32'h82, 32'd0, c_BU);
        chk("lbu_zero", rsp_rdata, 32'h00000080);
        issue(1'b1, 32'h80, 32'h1234, c_H);
        issue(1'b0, 32'h80, 32'd0, c_HU);
        chk("lhu", rsp_rdata, 32'h00001234);
        issue(1'b0, 32'h82, 32'd0, c_H);
        chk("lh_upper", rsp_rdata, 32'h00000080);
        issue(1'b0, 32'h80, 32'd0, c_W);
        chk("lw_merged", rsp_rdata, 32'h00801234);

        // Faults
        issue(1'b0, 32'h81, 32'd0, c_H);
        chk("lh_mis_fault", {31'd0, rsp_fault}, 32'd1);
        chk("lh_mis_rdata", rsp_rdata, 32'd0);
        issue(1'b1, 32'h42, 32'h11111111, c_W);
        chk("sw_mis_fault", {31'd0, rsp_fault}, 32'd1);
        chk("sw_mis_rdata", rsp_rdata, 32'd0);
        dbg_addr = 32'h10;
        #1;
        chk("sw_mis_nowrite", dbg_rdata, 32'hDEADBEEF);
        issue(1'b0, 32'h100, 32'd0, c_W);
        chk("lw_oob_fault", {31'd0, rsp_fault}, 32'd1);
        chk("lw_oob_rdata", rsp_rdata, 32'd0);
        issue(1'b1, 32'h0, 32'h5, 3'b011);
        chk("illegal_f3_fault", {31'd0, rsp_fault}, 32'd1);
        chk("illegal_f3_done", {31'd0, done_flag}, 32'd0);
        issue(1'b0, 32'h80, 32'd0, c_HU);
        chk("fault_clears", {31'd0, rsp_fault}, 32'd0);

        // Backpressure
        rsp_ready = 1'b1;
        step();
        chk("drain_valid", {31'd0, rsp_valid}, 32'd0);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h40;
        req_funct3 = c_W;
        #1;
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
            chk("bp_valid_hold", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata_hold", rsp_rdata, 32'hDEADBEEF);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk("b2b_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rdata", rsp_rdata, 32'h00801234);
        step();
        chk("b2b_drain", {31'd0, rsp_valid}, 32'd0);

        // Done flag and reset mid-response
        issue(1'b1, 32'h0, 32'h1, c_W);
        chk("done_set", {31'd0, done_flag}, 32'd1);
        issue(1'b1, 32'h43, 32'h77, c_B);
        chk("done_sticky", {31'd0, done_flag}, 32'd1);
        dbg_addr = 32'h10;
        #1;
        chk("sb_lane3", dbg_rdata, 32'h77ADBEEF);
        issue(1'b0, 32'h0, 32'd0, c_W);
        rsp_ready = 1'b0;
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rst_done", {31'd0, done_flag}, 32'd0);
        chk("async_rst_rdata", rsp_rdata, 32'd0);
        dbg_addr = 32'h0;
        #1;
        chk("rst_keeps_w0", dbg_rdata, 32'h00000001);
        dbg_addr = 32'h20;
        #1;
        chk("rst_keeps_w20", dbg_rdata, 32'h00801234);
        step();
        rst = 1'b0;
        step();
        issue(1'b0, 32'h40, 32'd0, c_W);
        chk("post_rst_lw", rsp_rdata, 32'h77ADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
